segment_capture: RTL
====================

# segment_capture

Receive-side counterpart of the 7-segment display path: samples seven external segment lines, such as a second board's display pins looped back onto input pins, and waits for each pattern to settle. Stable patterns are decoded back into a 4-bit hex digit. Each newly settled legal digit produces a one-cycle VALID strobe; blank and illegal patterns are flagged separately. The block sits between the input pins and any logic that consumes displayed values, for example a self-test checker for the display counter.

## Interface
- STABLE_CYCLES, default 16000: consecutive identical synchronized samples required to accept a pattern (1 ms at 16 MHz); legal range 2..2^20.
- CLK  input  1  system clock.
- RST_N  input  1  reset, asynchronous and active-low: asserts immediately, releases on a CLK edge.
- SEG_IN  input  7  segment lines; bit 0 = a, bit 6 = g (same bit order as the display driver output); active-high.
- DIGIT  output  4  last accepted legal hex value.
- VALID  output  1  one-cycle strobe: DIGIT was just updated.
- BLANK  output  1  level: the last accepted pattern was 7'h00.
- ERROR  output  1  one-cycle strobe: an illegal stable pattern was accepted.
- LOCKED  output  1  level: the current synchronized input has met STABLE_CYCLES.

## Operation
- SEG_IN passes through a two-flop synchronizer, giving the synchronized sample s2. All logic below uses s2.
- The stability counter has width $clog2(STABLE_CYCLES+1).
  - It clears to 0 whenever s2 differs from its previous value.
  - Otherwise it increments, saturating at STABLE_CYCLES.
- FSM states:
  - SETTLE (reset state): counter running, LOCKED=0. SETTLE→ACCEPT when the counter reaches STABLE_CYCLES-1 and s2 is unchanged.
  - ACCEPT (one cycle): decode the pattern and update the outputs, then go to LOCKED.
  - LOCKED: LOCKED=1. LOCKED→SETTLE on any change of s2.
- Decode table (gfedcba):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- In ACCEPT, the pattern is compared with the last accepted pattern, held in a "reported" register (a 7-bit pattern plus a have-reported flag).
  - Identical pattern: no strobe and no output change. A glitch that returns to the same pattern is never re-reported.
  - New legal pattern: DIGIT←value, VALID=1, BLANK←0.
  - 7'h00: BLANK←1, DIGIT held, no VALID.
  - Any other value: ERROR=1, DIGIT and BLANK held.
  - In all three cases the reported register is updated.
- The first accepted pattern after reset is always treated as new.
- VALID and ERROR are mutually exclusive, and each is high for exactly one cycle per accept.

## Timing
- Reset values: DIGIT=0, VALID=0, BLANK=0, ERROR=0, LOCKED=0. The synchronizer, counter and reported register are cleared; FSM=SETTLE.
- Latency: if a new value is first sampled at edge 0 and then held, VALID/ERROR are high after edge STABLE_CYCLES+2. LOCKED rises one edge later.
- A change of s2 lasting fewer than STABLE_CYCLES cycles produces no strobe.
- A change of s2 during LOCKED drops LOCKED on the same edge the counter clears.
- Asserting RST_N low mid-settle or mid-accept discards the pending pattern. No strobe is produced for that pattern; after release the block must re-accept from scratch.
- If s2 changes in the same cycle as ACCEPT, the accept completes with the old pattern and the FSM goes to SETTLE instead of LOCKED.
- All outputs are registered; none are combinational from SEG_IN.

## Configuration
- SEG_ACTIVE_LOW_EN defined: SEG_IN is inverted before the synchronizer (common-anode displays). The decode table, BLANK and all timing are unchanged in terms of logical segments.
- SEG_ACTIVE_LOW_EN undefined: SEG_IN is used as active-high.

## Test plan
- STABLE_CYCLES=4: reset, then hold SEG_IN=7'h4F → VALID high for 1 cycle after edge 6, DIGIT=3, LOCKED=1 after edge 7.
- Step 7'h06 → 7'h5B → 7'h77, each held 10 cycles → three VALID pulses with DIGIT=1, 2, A.
- While accepted at 7'h66, apply a 3-cycle glitch to 7'h7F, then return to 7'h66 → no VALID, DIGIT stays 4, LOCKED drops and then re-asserts.
- Hold 7'h00 → BLANK=1, no VALID. Then hold 7'h49 → ERROR pulse, DIGIT unchanged. Then hold 7'h3F → VALID, DIGIT=0, BLANK=0.
- Pull RST_N low 2 cycles into settling 7'h6D, release, keep SEG_IN at 7'h6D → exactly one VALID (DIGIT=5), appearing 6 edges after the release edge.
- With SEG_ACTIVE_LOW_EN defined, hold SEG_IN=7'h40 (logical 3F) → VALID, DIGIT=0.

Source files
------------

// File: rtl/segment_capture.sv
// segment_capture: synchronizes and debounces seven segment lines, then decodes settled patterns to hex.
// Build option SEG_ACTIVE_LOW_EN: SEG_IN is inverted at the pins for common-anode displays.
module segment_capture #(
  parameter int STABLE_CYCLES = 16000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] SEG_IN,
  output logic [3:0] DIGIT,
  output logic       VALID,
  output logic       BLANK,
  output logic       ERROR,
  output logic       LOCKED
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Returns {legal, value}; legal is low for blank and for any non-hex pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h3F:   res = {1'b1, 4'h0};
      7'h06:   res = {1'b1, 4'h1};
      7'h5B:   res = {1'b1, 4'h2};
      7'h4F:   res = {1'b1, 4'h3};
      7'h66:   res = {1'b1, 4'h4};
      7'h6D:   res = {1'b1, 4'h5};
      7'h7D:   res = {1'b1, 4'h6};
      7'h07:   res = {1'b1, 4'h7};
      7'h7F:   res = {1'b1, 4'h8};
      7'h6F:   res = {1'b1, 4'h9};
      7'h77:   res = {1'b1, 4'hA};
      7'h7C:   res = {1'b1, 4'hB};
      7'h39:   res = {1'b1, 4'hC};
      7'h5E:   res = {1'b1, 4'hD};
      7'h79:   res = {1'b1, 4'hE};
      7'h71:   res = {1'b1, 4'hF};
      default: res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  logic [6:0]       seg_log_s;
  logic [6:0]       sync1_r;
  logic [6:0]       sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             chg_s;
  logic             new_pat_s;
  logic [4:0]       dec_s;
  logic [6:0]       rep_pat_r;
  logic             rep_vld_r;
  logic [3:0]       digit_r;
  logic             valid_r;
  logic             blank_r;
  logic             error_r;
  logic             locked_r;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_log_s = ~SEG_IN;
`else
  assign seg_log_s = SEG_IN;
`endif

  // A change is seen on the edge that loads a different value into s2, so the
  // counter restarts from 0 on that same edge.
  assign chg_s     = (sync1_r != sync2_r);
  assign dec_s     = seg_decode(sync2_r);
  assign new_pat_s = !rep_vld_r || (rep_pat_r != sync2_r);

  // Two-flop synchronizer on the logical segment lines.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_r <= 7'h00;
      sync2_r <= 7'h00;
    end else begin
      sync1_r <= seg_log_s;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter, saturating at STABLE_CYCLES.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r <= '0;
    end else if (chg_s) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_SETTLE: begin
        if (!chg_s && (cnt_r >= CNT_HIT)) begin
          state_nxt_s = ST_ACCEPT;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_ACCEPT: begin
        if (chg_s) begin
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (chg_s) begin
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      default: state_nxt_s = ST_SETTLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_SETTLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Accept handling: the pattern in s2 during ACCEPT is the one that settled,
  // even if a new value is already arriving behind it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rep_pat_r <= 7'h00;
      rep_vld_r <= 1'b0;
      digit_r   <= 4'h0;
      valid_r   <= 1'b0;
      blank_r   <= 1'b0;
      error_r   <= 1'b0;
      locked_r  <= 1'b0;
    end else begin
      valid_r  <= 1'b0;
      error_r  <= 1'b0;
      locked_r <= (state_r == ST_LOCKED) && !chg_s;
      if ((state_r == ST_ACCEPT) && new_pat_s) begin
        rep_pat_r <= sync2_r;
        rep_vld_r <= 1'b1;
        if (dec_s[4]) begin
          digit_r <= dec_s[3:0];
          valid_r <= 1'b1;
          blank_r <= 1'b0;
        end else if (sync2_r == 7'h00) begin
          blank_r <= 1'b1;
        end else begin
          error_r <= 1'b1;
        end
      end
    end
  end

  assign DIGIT  = digit_r;
  assign VALID  = valid_r;
  assign BLANK  = blank_r;
  assign ERROR  = error_r;
  assign LOCKED = locked_r;

endmodule
